rblwe_encrypt: RTL
==================

// Module: rblwe_encrypt
// PURPOSE
// - Ring-Binary-LWE encryption stage that sits directly upstream of the decryptor and produces the (c1, c2) ciphertext pair it consumes.
// - Computes c1 = a*e1 + e2 and c2 = p*e1 + e3 + encode(m) over Z_q[x]/(x^N+1).
// - Multiplication is bit-serial Horner over binary e1: one coefficient of e1 per clock, N clocks per encryption.
// PARAMETERS
// - N      256  ring degree; polynomial length in coefficients.
// - LOG_Q  8    coefficient width in bits; Q = 2^LOG_Q, so all arithmetic wraps mod 2^LOG_Q.
// PORTS
// - clk    in   1          single clock; all state changes on posedge.
// - rst    in   1          reset, synchronous, active-low.
// - start  in   1          request; sampled only in IDLE.
// - a      in   N*LOG_Q    public polynomial; coefficient i = a[i*LOG_Q +: LOG_Q].
// - p      in   N*LOG_Q    public key polynomial; same packing as a.
// - e1     in   N          binary error polynomial; bit i = coefficient i.
// - e2     in   N          binary error polynomial added to c1.
// - e3     in   N          binary error polynomial added to c2.
// - m      in   N          message bits; bit i encodes into coefficient i.
// - c1     out  N*LOG_Q    ciphertext part 1; packed as a.
// - c2     out  N*LOG_Q    ciphertext part 2; packed as a.
// - valid  out  1          c1/c2 stable and valid; held until ack.
// - busy   out  1          high in MUL, ADD and DONE.
// - ack    in   1          consumer has taken c1/c2; meaningful only while valid=1.
// BEHAVIOUR
// - Reset (rst=0 at posedge): state=IDLE; acc1, acc2, c1, c2 = 0; valid=0; busy=0; cnt=0. Reset wins over every other input, in any state.
// - IDLE: if start=1, latch a, p, e1, e2, e3, m into internal registers; clear acc1 and acc2; cnt=0; go to MUL. Inputs may change freely after this cycle.
// - MUL (N cycles):
//   - Take bit b = e1_reg[N-1-cnt].
//   - acc <= (acc*x mod x^N+1) + b*poly, applied to both acc1/a and acc2/p.
//   - acc*x is negacyclic: new[0] = (-acc[N-1]) mod Q = ~acc[N-1]+1; new[j] = acc[j-1] for j>=1.
//   - Addition per coefficient, LOG_Q-bit wrap; carries are discarded.
//   - cnt increments each cycle; when cnt==N-1, go to ADD.
// - ADD (1 cycle):
//   - c1[i] <= acc1[i] + e2[i].
//   - c2[i] <= acc2[i] + e3[i] + (m[i] ? Q/2 : 0). All sums wrap mod Q.
//   - Go to DONE.
// - DONE: valid=1; c1 and c2 are held. When ack=1, valid goes to 0 and state returns to IDLE on the next edge. ack outside DONE is ignored.
// - Latency: start sampled at edge T -> valid=1 from edge T+N+2.
// - start asserted in MUL, ADD or DONE is ignored; there is no queueing.
// - In DONE, start and ack may be high together: ack is honoured, and start is sampled in IDLE one cycle later.
// - c1 and c2 keep their last values in IDLE until the next ADD overwrites them.
// STRUCTURE
// - Shared package/defines: N, LOG_Q, Q, Q_HALF=Q/2, state encodings (IDLE=2'b00, MUL=2'b01, ADD=2'b10, DONE=2'b11), and a per-coefficient slice helper.
// - Sub-module rblwe_negacyclic_mac: combinational, one Horner step (acc, poly, bit) -> next acc.
//   - Instantiated twice, once for a and once for p.
// - Top level holds the FSM, cnt, input latches and the ADD/encode logic.
// TESTING
// - Zero test: all inputs 0, start pulse -> valid at T+N+2; c1 = c2 = 0.
// - Identity multiply: e1 = 1 (bit 0 only), a[i] = i, e2 = 0 -> c1[i] = i for all i.
// - Negacyclic wrap: e1 = bit 1 only, a[N-1] = 5, other a = 0 -> c1[0] = 251, all other c1 = 0.
// - Encoding: m = all ones, p = e1 = e3 = 0 -> every c2 coefficient = 128.
//   - Also e3 = all ones with m[0] = 1 -> c2[0] = 129, c2[1] = 1.
// - Reset mid-MUL: rst=0 at cnt=100 -> next cycle state = IDLE, valid = 0, acc = 0.
//   - A new start then gives the correct result.
// - Handshake:
//   - Hold ack=0 for 10 cycles in DONE -> valid and c1/c2 stay constant.
//   - Then ack=1 -> IDLE.
//   - start pulses during MUL produce no second result.

Source files
------------

// File: rtl/rblwe_pkg.sv
// Shared types and constants for the Ring-Binary-LWE encryptor.
package rblwe_pkg;

    localparam int N      = 256;
    localparam int LOG_Q  = 8;
    localparam int Q      = 1 << LOG_Q;
    localparam int Q_HALF = Q / 2;
    localparam int CNT_W  = $clog2(N);

    typedef logic [LOG_Q-1:0]   coef_t;
    typedef logic [N*LOG_Q-1:0] poly_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        ADD  = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic coef_t coef(input poly_t v, input int unsigned i);
        return v[i*LOG_Q +: LOG_Q];
    endfunction

endpackage

// File: rtl/rblwe_negacyclic_mac.sv
// One Horner step over Z_q[x]/(x^N+1): nxt = acc*x + b*poly.
module rblwe_negacyclic_mac
    import rblwe_pkg::*;
(
    input  poly_t acc,
    input  poly_t poly,
    input  logic  b,
    output poly_t nxt
);

    for (genvar j = 0; j < N; j++) begin : g_coef
        coef_t sh;
        coef_t term;
        // x^N = -1, so the top coefficient wraps to slot 0 negated
        if (j == 0) begin : g_wrap
            assign sh = ~coef(acc, N-1) + coef_t'(1);
        end else begin : g_shift
            assign sh = coef(acc, j-1);
        end
        assign term = b ? coef(poly, j) : '0;
        assign nxt[j*LOG_Q +: LOG_Q] = sh + term;
    end

endmodule

// File: rtl/rblwe_encrypt.sv
// RB-LWE encryption: c1 = a*e1 + e2, c2 = p*e1 + e3 + encode(m).
module rblwe_encrypt
    import rblwe_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  poly_t        a,
    input  poly_t        p,
    input  logic [N-1:0] e1,
    input  logic [N-1:0] e2,
    input  logic [N-1:0] e3,
    input  logic [N-1:0] m,
    output poly_t        c1,
    output poly_t        c2,
    output logic         valid,
    output logic         busy,
    input  logic         ack
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    poly_t            a_r;
    poly_t            p_r;
    logic [N-1:0]     e1_r;
    logic [N-1:0]     e2_r;
    logic [N-1:0]     e3_r;
    logic [N-1:0]     m_r;
    poly_t            acc1;
    poly_t            acc2;
    poly_t            mac1;
    poly_t            mac2;
    poly_t            c1_nxt;
    poly_t            c2_nxt;
    logic             bit_e;

    assign bit_e = e1_r[CNT_W'(N-1) - cnt];
    assign busy  = (state != IDLE);

    rblwe_negacyclic_mac u_mac_a (
        .acc  (acc1),
        .poly (a_r),
        .b    (bit_e),
        .nxt  (mac1)
    );

    rblwe_negacyclic_mac u_mac_p (
        .acc  (acc2),
        .poly (p_r),
        .b    (bit_e),
        .nxt  (mac2)
    );

    for (genvar i = 0; i < N; i++) begin : g_add
        coef_t enc;
        assign enc = m_r[i] ? coef_t'(Q_HALF) : '0;
        assign c1_nxt[i*LOG_Q +: LOG_Q] = coef(acc1, i) + coef_t'(e2_r[i]);
        assign c2_nxt[i*LOG_Q +: LOG_Q] = coef(acc2, i) + coef_t'(e3_r[i]) + enc;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = MUL;
            MUL:  if (cnt == CNT_W'(N-1)) state_nxt = ADD;
            ADD:  state_nxt = DONE;
            DONE: if (valid && ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc1  <= '0;
            acc2  <= '0;
            c1    <= '0;
            c2    <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        p_r  <= p;
                        e1_r <= e1;
                        e2_r <= e2;
                        e3_r <= e3;
                        m_r  <= m;
                        acc1 <= '0;
                        acc2 <= '0;
                        cnt  <= '0;
                    end
                end
                MUL: begin
                    acc1 <= mac1;
                    acc2 <= mac2;
                    cnt  <= cnt + CNT_W'(1);
                end
                ADD: begin
                    c1 <= c1_nxt;
                    c2 <= c2_nxt;
                end
                DONE: valid <= !(valid && ack);
                default: valid <= 1'b0;
            endcase
        end
    end

endmodule
